// File: rtl/retire_async_sync_bridge.sv
// Bundled-data drive/free to clocked valid/ready bridge for the retire path.
// Optional RETIRE_BRIDGE_XFER_CNT_EN adds a 16-bit wrapping pop counter output.
module retire_async_sync_bridge #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_drive,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_free,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overrun
`ifdef RETIRE_BRIDGE_XFER_CNT_EN
    ,
    output logic [15:0]              o_xfer_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FREE  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0]  cap_data_q;
    logic                   req_tog_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync_s;
    logic                   req_seen_q, req_seen_d;
    logic                   pending_s;
    state_t                 state_q, state_d;
    logic                   free_q, free_d;
    logic                   overrun_q, overrun_d;
    logic                   push_s, pop_s, full_s, empty_s;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    // Capture bundled data and flip the request toggle on each drive edge.
    always_ff @(posedge i_drive or negedge rstn) begin
        if (!rstn) begin
            cap_data_q <= '0;
            req_tog_q  <= 1'b0;
        end else begin
            cap_data_q <= i_data;
            req_tog_q  <= ~req_tog_q;
        end
    end

    // Request toggle synchronizer into the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tog_q};
        end
    end

    assign req_sync_s = sync_q[SYNC_STAGES-1];
    assign pending_s  = req_sync_s ^ req_seen_q;
    assign empty_s    = (wr_ptr_q == rd_ptr_q);
    assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_s      = ~empty_s & i_ready;

    // Handshake FSM next-state; a toggle that returns to req_seen in STALL means a word was lost.
    always_comb begin
        state_d    = state_q;
        req_seen_d = req_seen_q;
        free_d     = 1'b0;
        overrun_d  = overrun_q;
        push_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_s && !full_s) begin
                    push_s     = 1'b1;
                    req_seen_d = req_sync_s;
                    free_d     = 1'b1;
                    state_d    = FREE;
                end else if (pending_s) begin
                    state_d = STALL;
                end else begin
                    state_d = IDLE;
                end
            end
            STALL: begin
                if (!pending_s) begin
                    overrun_d = 1'b1;
                    state_d   = IDLE;
                end else if (!full_s || pop_s) begin
                    push_s     = 1'b1;
                    req_seen_d = req_sync_s;
                    free_d     = 1'b1;
                    state_d    = FREE;
                end else begin
                    state_d = STALL;
                end
            end
            FREE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            req_seen_q <= 1'b0;
            free_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_seen_q <= req_seen_d;
            free_q     <= free_d;
            overrun_q  <= overrun_d;
        end
    end

    // FIFO storage and pointers; a full-FIFO push with same-cycle pop reuses the head slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= cap_data_q;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

`ifdef RETIRE_BRIDGE_XFER_CNT_EN
    logic [15:0] xfer_cnt_q;

    // Wrapping count of entries handed downstream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xfer_cnt_q <= 16'd0;
        end else if (pop_s) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end else begin
            xfer_cnt_q <= xfer_cnt_q;
        end
    end

    assign o_xfer_cnt = xfer_cnt_q;
`endif

    assign o_free    = free_q;
    assign o_overrun = overrun_q;
    assign o_valid   = ~empty_s;
    assign o_data    = mem_q[rd_ptr_q[AW-1:0]];
    assign o_count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_retire_async_sync_bridge.sv
// Randomized self-checking bench for retire_async_sync_bridge with a queue scoreboard.
module tb_retire_async_sync_bridge;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_drive = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_ready = 1'b0;
    logic          o_free, o_valid, o_overrun;
    logic [DW-1:0] o_data;
    logic [2:0]    o_count;
`ifdef RETIRE_BRIDGE_XFER_CNT_EN
    logic [15:0]   o_xfer_cnt;
`endif

    int            n_checks = 0;
    int            n_fail = 0;
    int            free_cnt = 0;
    int            pop_total = 0;
    logic          prev_free = 1'b0;
    logic          tog_en = 1'b0;
    logic [DW-1:0] exp_q[$];

    retire_async_sync_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_drive   (i_drive),
        .i_data    (i_data),
        .o_free    (o_free),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .i_ready   (i_ready),
        .o_count   (o_count),
        .o_overrun (o_overrun)
`ifdef RETIRE_BRIDGE_XFER_CNT_EN
        ,
        .o_xfer_cnt(o_xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every accepted pop must match the oldest word the bench expects to be stored.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_free = 1'b0;
        end else begin
            if (o_free) begin
                free_cnt++;
                check_eq("free_one_cycle", {63'd0, prev_free}, 64'd0);
            end
            prev_free = o_free;
            if (o_valid && i_ready) begin
                pop_total++;
                if (exp_q.size() == 0) begin
                    check_eq("pop_unexpected", 64'd1, 64'd0);
                end else begin
                    check_eq("pop_data", {32'd0, o_data}, {32'd0, exp_q.pop_front()});
                end
                check_eq("count_le_depth", {63'd0, (o_count <= 3'd4)}, 64'd1);
            end
        end
    end

    // Toggles i_ready every cycle while enabled.
    always begin
        @(posedge clk);
        #1;
        if (tog_en) i_ready = ~i_ready;
    end

    task automatic wait_free(input int f0, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (free_cnt > f0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq(tag, 64'd0, 64'd1);
    endtask

    task automatic drive(input logic [DW-1:0] d, input bit stored, input bit wait_for_free);
        int f0 = free_cnt;
        @(posedge clk);
        #1;
        i_data = d;
        if (stored) exp_q.push_back(d);
        #1 i_drive = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_drive = 1'b0;
        if (wait_for_free) wait_free(f0, "free_timeout");
    endtask

    task automatic drain(input string tag);
        i_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && o_count == 3'd0) break;
        end
        #1;
        check_eq({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_count_zero"}, {61'd0, o_count}, 64'd0);
    endtask

    initial begin
        int lat;
        int f0;
        logic [DW-1:0] d;

        // Reset state.
        #12;
        check_eq("rst_valid", {63'd0, o_valid}, 64'd0);
        check_eq("rst_count", {61'd0, o_count}, 64'd0);
        check_eq("rst_free", {63'd0, o_free}, 64'd0);
        check_eq("rst_overrun", {63'd0, o_overrun}, 64'd0);
        check_eq("rst_data", {32'd0, o_data}, 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // 1: single transfer, latency and free/valid alignment.
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_data = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        #1 i_drive = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (o_valid) break;
        end
        check_eq("t1_latency_ok", {63'd0, (lat >= 3 && lat <= 4)}, 64'd1);
        check_eq("t1_free_with_valid", {63'd0, o_free}, 64'd1);
        check_eq("t1_data", {32'd0, o_data}, 64'hDEADBEEF);
        #2 i_drive = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_eq("t1_count_after_pop", {61'd0, o_count}, 64'd0);

        // 2: fill, stall on 5th, release with same-cycle push/pop.
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) drive(DW'(k), 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1 check_eq("t2_count_full", {61'd0, o_count}, 64'd4);
        f0 = free_cnt;
        drive(32'h5, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1 check_eq("t2_no_free_in_stall", 64'(free_cnt), 64'(f0));
        check_eq("t2_count_stall", {61'd0, o_count}, 64'd4);
        i_ready = 1'b1;
        wait_free(f0, "t2_free_after_pop");
        drain("t2");

        // 3: second drive while stalled is an overrun; neither word is stored.
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive(32'h100 + DW'(k), 1'b1, 1'b1);
        f0 = free_cnt;
        drive(32'h5, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        drive(32'h6, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 check_eq("t3_overrun", {63'd0, o_overrun}, 64'd1);
        check_eq("t3_count", {61'd0, o_count}, 64'd4);
        check_eq("t3_no_free", 64'(free_cnt), 64'(f0));
        drain("t3");
        check_eq("t3_overrun_sticky", {63'd0, o_overrun}, 64'd1);

        // 4: random words with i_ready toggling every cycle; pointers wrap repeatedly.
        tog_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            d = $urandom;
            drive(d, 1'b1, 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        tog_en = 1'b0;
        drain("t4");
        check_eq("t4_overrun_sticky", {63'd0, o_overrun}, 64'd1);

        // 5: reset while stalled on a full FIFO, then normal delivery.
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive(32'h200 + DW'(k), 1'b1, 1'b1);
        drive(32'h77, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check_eq("t5_valid", {63'd0, o_valid}, 64'd0);
        check_eq("t5_count", {61'd0, o_count}, 64'd0);
        check_eq("t5_free", {63'd0, o_free}, 64'd0);
        check_eq("t5_overrun", {63'd0, o_overrun}, 64'd0);
        exp_q.delete();
        pop_total = 0;
        @(posedge clk);
        #1 rstn = 1'b1;
        i_ready = 1'b1;
        drive(32'hA5, 1'b1, 1'b1);
        drain("t5");
        check_eq("t5_overrun_clear", {63'd0, o_overrun}, 64'd0);

`ifdef RETIRE_BRIDGE_XFER_CNT_EN
        // 6: pop counter tracks pops since reset.
        for (int k = 0; k < 3; k++) drive($urandom, 1'b1, 1'b1);
        drain("t6");
        check_eq("t6_xfer_cnt", {48'd0, o_xfer_cnt}, 64'(pop_total[15:0]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
